// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory-controller port between instruction fetch and
// the data (MEM) stage. Data wins by default; a starvation guard forces a fetch grant after
// STARVE_LIMIT consecutive denied fetch cycles. One-cycle read data is steered back to the
// requester that issued the load.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // Data-stage requester
  input  logic        d_req,
  input  logic        d_is_store,
  input  logic [2:0]  d_mem_wren,
  input  logic [2:0]  d_load_val,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_w_data,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // Fetch requester
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  // Memory controller port
  output logic        mc_is_store,
  output logic        mc_is_load,
  output logic [2:0]  mc_mem_wren,
  output logic [2:0]  mc_load_val,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_w_data,
  input  logic [31:0] mc_read_data
);

  typedef enum logic [1:0] {OwnNone, OwnData, OwnFetch} owner_e;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  owner_e     resp_owner_q, resp_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       force_fetch;

  assign force_fetch = (starve_cnt_q == Limit);

  // Grant decision: fetch only wins when data is absent or fetch has been starved too long.
  always_comb begin
    f_gnt = !reset && f_req && (!d_req || force_fetch);
    d_gnt = !reset && d_req && !f_gnt;
  end

  // Memory port mux; idle values keep wren at 111 so a byte store can never leak to the UART.
  always_comb begin
    mc_is_store = 1'b0;
    mc_is_load  = 1'b0;
    mc_mem_wren = 3'b111;
    mc_load_val = 3'b111;
    mc_addr     = '0;
    mc_w_data   = '0;
    if (f_gnt) begin
      mc_is_load  = 1'b1;
      mc_load_val = 3'b010;
      mc_addr     = f_addr;
    end else if (d_gnt) begin
      mc_is_store = d_is_store;
      mc_is_load  = !d_is_store;
      mc_mem_wren = d_mem_wren;
      mc_load_val = d_load_val;
      mc_addr     = d_addr;
      mc_w_data   = d_w_data;
    end
  end

  // Next-state for the starvation counter and the response owner.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!f_req || f_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < Limit) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    resp_owner_d = OwnNone;
    if (f_gnt) begin
      resp_owner_d = OwnFetch;
    end else if (d_gnt && !d_is_store) begin
      resp_owner_d = OwnData;
    end
  end

  // State registers with synchronous reset; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      resp_owner_q <= OwnNone;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // Read data is shared and unregistered; rvalid tells each requester whether it is theirs.
  always_comb begin
    d_rvalid = (resp_owner_q == OwnData);
    f_rvalid = (resp_owner_q == OwnFetch);
    d_rdata  = mc_read_data;
    f_rdata  = mc_read_data;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: memory-controller model, reference model with a response
// scoreboard, directed scenarios and a randomized phase.
module tb_mem_port_arbiter;
  localparam int unsigned LIMIT     = 4;
  localparam logic [31:0] BASE      = 32'h0000_6100;
  localparam logic [31:0] UART_ADDR = 32'h0000_7000;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_req, d_is_store;
  logic [2:0]  d_mem_wren, d_load_val;
  logic [31:0] d_addr, d_w_data;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt, f_rvalid;
  logic [31:0] f_rdata;
  logic        mc_is_store, mc_is_load;
  logic [2:0]  mc_mem_wren, mc_load_val;
  logic [31:0] mc_addr, mc_w_data;
  logic [31:0] mc_read_data = '0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_is_store(d_is_store), .d_mem_wren(d_mem_wren), .d_load_val(d_load_val),
    .d_addr(d_addr), .d_w_data(d_w_data), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .mc_is_store(mc_is_store), .mc_is_load(mc_is_load),
    .mc_mem_wren(mc_mem_wren), .mc_load_val(mc_load_val), .mc_addr(mc_addr),
    .mc_w_data(mc_w_data), .mc_read_data(mc_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Load formatting as the memory controller applies it.
  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off,
                                      input logic [2:0] lv);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * off));
    h = 16'(w >> (16 * off[1]));
    case (lv)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- memory controller environment ----------------
  logic [7:0] env_mem [64];
  int         uart_writes = 0;
  logic [7:0] uart_last = '0;

  function automatic logic [31:0] env_word(input logic [31:0] a);
    return {env_mem[{a[5:2], 2'd3}], env_mem[{a[5:2], 2'd2}],
            env_mem[{a[5:2], 2'd1}], env_mem[{a[5:2], 2'd0}]};
  endfunction

  always @(posedge clk) begin
    if (mc_is_store) begin
      if (mc_addr == UART_ADDR) begin
        uart_writes <= uart_writes + 1;
        uart_last   <= mc_w_data[7:0];
      end else begin
        case (mc_mem_wren)
          3'b000: env_mem[mc_addr[5:0]] <= mc_w_data[7:0];
          3'b001: begin
            env_mem[{mc_addr[5:1], 1'b0}] <= mc_w_data[7:0];
            env_mem[{mc_addr[5:1], 1'b1}] <= mc_w_data[15:8];
          end
          3'b010: for (int k = 0; k < 4; k++) env_mem[{mc_addr[5:2], 2'(k)}] <= mc_w_data[8*k +: 8];
          default: ;
        endcase
      end
    end
    if (mc_is_load) mc_read_data <= fmt(env_word(mc_addr), mc_addr[1:0], mc_load_val);
  end

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] ref_mem [64];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[{a[5:2], 2'd3}], ref_mem[{a[5:2], 2'd2}],
            ref_mem[{a[5:2], 2'd1}], ref_mem[{a[5:2], 2'd0}]};
  endfunction

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    int          due;
  } resp_t;
  resp_t q[$];
  int    denied = 0;

  // Model: decide the winner from the priority/starvation rules and predict the port drive.
  always @(negedge clk) begin
    bit exp_f, exp_d;
    if (reset) begin
      exp_f = 1'b0;
      exp_d = 1'b0;
    end else begin
      exp_f = f_req && (!d_req || denied == LIMIT);
      exp_d = d_req && !exp_f;
    end
    check("f_gnt", {31'b0, f_gnt}, {31'b0, exp_f});
    check("d_gnt", {31'b0, d_gnt}, {31'b0, exp_d});
    if (exp_f) begin
      check("mc_f_ctl", {27'b0, mc_is_store, mc_is_load, mc_load_val}, {27'b0, 2'b01, 3'b010});
      check("mc_f_addr", mc_addr, f_addr);
      check("mc_f_wdata", mc_w_data, 32'h0);
      q.push_back('{is_data: 1'b0, data: ref_word(f_addr), due: cyc + 1});
    end else if (exp_d) begin
      check("mc_d_ctl", {26'b0, mc_is_store, mc_is_load, mc_mem_wren, mc_load_val},
            {26'b0, d_is_store, !d_is_store, d_mem_wren, d_load_val});
      check("mc_d_addr", mc_addr, d_addr);
      check("mc_d_wdata", mc_w_data, d_w_data);
      if (!d_is_store) begin
        q.push_back('{is_data: 1'b1, data: fmt(ref_word(d_addr), d_addr[1:0], d_load_val),
                      due: cyc + 1});
      end else if (d_addr != UART_ADDR) begin
        case (d_mem_wren)
          3'b000: ref_mem[d_addr[5:0]] = d_w_data[7:0];
          3'b001: begin
            ref_mem[{d_addr[5:1], 1'b0}] = d_w_data[7:0];
            ref_mem[{d_addr[5:1], 1'b1}] = d_w_data[15:8];
          end
          3'b010: for (int k = 0; k < 4; k++) ref_mem[{d_addr[5:2], 2'(k)}] = d_w_data[8*k +: 8];
          default: ;
        endcase
      end
    end else begin
      check("mc_idle", {26'b0, mc_is_store, mc_is_load, mc_mem_wren, mc_load_val},
            {26'b0, 2'b00, 3'b111, 3'b111});
      check("mc_idle_addr", mc_addr | mc_w_data, 32'h0);
    end
    if (reset || !f_req || exp_f) denied = 0;
    else if (denied < LIMIT) denied++;
  end

  // Monitor: every rvalid must match the oldest outstanding expected response, on time.
  always @(negedge clk) begin
    resp_t r;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      check("rvalid_owner", {30'b0, d_rvalid, f_rvalid}, r.is_data ? 32'd2 : 32'd1);
      check("rdata", r.is_data ? d_rdata : f_rdata, r.data);
    end else begin
      check("rvalid_idle", {30'b0, d_rvalid, f_rvalid}, 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      env_mem[{a[5:2], 2'(k)}] <= w[8*k +: 8];
      ref_mem[{a[5:2], 2'(k)}] = w[8*k +: 8];
    end
  endtask

  task automatic set_data(input logic st, input logic [2:0] wren, input logic [2:0] lv,
                          input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_is_store = st; d_mem_wren = wren; d_load_val = lv;
    d_addr = a; d_w_data = wd;
  endtask

  task automatic new_data_req();
    logic [5:0]  off;
    logic [2:0]  lvs [5];
    logic [2:0]  lv;
    logic [2:0]  wren;
    logic [31:0] a;
    lvs[0] = 3'b000; lvs[1] = 3'b001; lvs[2] = 3'b010; lvs[3] = 3'b100; lvs[4] = 3'b101;
    off = 6'($urandom_range(0, 63));
    if ($urandom_range(0, 1) == 1) begin
      wren = 3'($urandom_range(0, 2));
      if (wren == 3'b001) off[0] = 1'b0;
      if (wren == 3'b010) off[1:0] = 2'b00;
      a = ($urandom_range(0, 19) == 0) ? UART_ADDR : (BASE | {26'b0, off});
      if (a == UART_ADDR) wren = 3'b000;
      set_data(1'b1, wren, 3'b010, a, $urandom);
    end else begin
      lv = lvs[$urandom_range(0, 4)];
      if (lv[1:0] == 2'b01) off[0] = 1'b0;
      if (lv == 3'b010) off[1:0] = 2'b00;
      set_data(1'b0, 3'b111, lv, BASE | {26'b0, off}, $urandom);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int u0;
    bit dg, fg;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      env_mem[i] <= v;
      ref_mem[i] = v;
    end
    reset = 1'b1;
    set_data(1'b0, 3'b111, 3'b010, BASE, 32'h0);
    f_req = 1'b1; f_addr = BASE;

    // Reset: no grants, idle port, no rvalid.
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", {30'b0, d_gnt, f_gnt}, 32'd0);
      check("rst_rvalid", {30'b0, d_rvalid, f_rvalid}, 32'd0);
      check("rst_wren", {29'b0, mc_mem_wren}, 32'd7);
    end
    step();
    reset = 1'b0; d_req = 1'b0; f_req = 1'b0;
    step();

    // Lone fetch.
    preload_word(BASE, 32'h0050_0093);
    f_req = 1'b1; f_addr = BASE;
    @(negedge clk); check("lone_f_gnt", {31'b0, f_gnt}, 32'd1);
    step(); f_req = 1'b0;
    @(negedge clk);
    check("lone_f_rvalid", {30'b0, d_rvalid, f_rvalid}, 32'd1);
    check("lone_f_rdata", f_rdata, 32'h0050_0093);
    step();

    // Data priority over fetch.
    preload_word(BASE + 32'h4, 32'h1234_5678);
    preload_word(BASE + 32'h8, 32'hCAFE_F00D);
    set_data(1'b0, 3'b111, 3'b010, BASE + 32'h4, 32'h0);
    f_req = 1'b1; f_addr = BASE + 32'h8;
    @(negedge clk); check("prio_gnt", {30'b0, d_gnt, f_gnt}, 32'd2);
    step(); d_req = 1'b0;
    @(negedge clk);
    check("prio_d_rdata", d_rvalid ? d_rdata : 32'hDEAD_DEAD, 32'h1234_5678);
    check("prio_starve", {28'b0, dut.starve_cnt_q}, 32'd1);
    check("prio_f_after", {31'b0, f_gnt}, 32'd1);
    step(); f_req = 1'b0;
    @(negedge clk); check("prio_f_rdata", f_rvalid ? f_rdata : 32'hDEAD_DEAD, 32'hCAFE_F00D);
    step();

    // Starvation: both held; fetch forced every fifth cycle.
    set_data(1'b0, 3'b111, 3'b010, BASE + 32'h4, 32'h0);
    f_req = 1'b1; f_addr = BASE;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("starve_pattern", {30'b0, d_gnt, f_gnt}, (k % 5 == 4) ? 32'd1 : 32'd2);
      step();
    end
    d_req = 1'b0; f_req = 1'b0;
    step();

    // Store byte then load back unsigned and signed.
    set_data(1'b1, 3'b000, 3'b111, BASE + 32'h2, 32'h0000_00A5);
    @(negedge clk); check("sb_gnt", {31'b0, d_gnt}, 32'd1);
    step(); set_data(1'b0, 3'b111, 3'b100, BASE + 32'h2, 32'h0);
    @(negedge clk); check("sb_no_rvalid", {31'b0, d_rvalid}, 32'd0);
    step(); set_data(1'b0, 3'b111, 3'b000, BASE + 32'h2, 32'h0);
    @(negedge clk); check("lbu_rdata", d_rvalid ? d_rdata : 32'hDEAD_DEAD, 32'h0000_00A5);
    step(); d_req = 1'b0;
    @(negedge clk); check("lb_rdata", d_rvalid ? d_rdata : 32'hDEAD_DEAD, 32'hFFFF_FFA5);
    step();

    // UART safety: idle port stays at wren 111; one write only on the grant cycle.
    u0 = uart_writes;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("uart_idle", {28'b0, mc_is_store, mc_mem_wren}, 32'd7);
      step();
    end
    set_data(1'b1, 3'b000, 3'b111, UART_ADDR, 32'h0000_0041);
    @(negedge clk); check("uart_gnt", {31'b0, d_gnt}, 32'd1);
    step(); d_req = 1'b0;
    repeat (3) step();
    check("uart_count", 32'(uart_writes - u0), 32'd1);
    check("uart_data", {24'b0, uart_last}, 32'h41);

    // Reset while requests are pending.
    set_data(1'b0, 3'b111, 3'b010, BASE + 32'h4, 32'h0);
    f_req = 1'b1; f_addr = BASE; reset = 1'b1;
    @(negedge clk); check("rstq_gnt0", {30'b0, d_gnt, f_gnt}, 32'd0);
    step();
    @(negedge clk);
    check("rstq_gnt1", {30'b0, d_gnt, f_gnt}, 32'd0);
    check("rstq_rvalid", {30'b0, d_rvalid, f_rvalid}, 32'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    check("rstq_starve", {28'b0, dut.starve_cnt_q}, 32'd0);
    check("rstq_d_first", {30'b0, d_gnt, f_gnt}, 32'd2);
    step(); d_req = 1'b0;
    @(negedge clk); check("rstq_f_next", {31'b0, f_gnt}, 32'd1);
    step(); f_req = 1'b0;

    // Randomized traffic with occasional resets and abandoned fetches.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      dg = d_gnt; fg = f_gnt;
      step();
      reset = ($urandom_range(0, 59) == 0);
      if (d_req && dg) d_req = 1'b0;
      if (!d_req && $urandom_range(0, 2) != 0) new_data_req();
      if (f_req && fg) f_req = 1'b0;
      else if (f_req && $urandom_range(0, 9) == 0) f_req = 1'b0;
      if (!f_req && $urandom_range(0, 3) != 0) begin
        f_req = 1'b1;
        f_addr = BASE | {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      end
    end
    reset = 1'b0; d_req = 1'b0; f_req = 1'b0;
    repeat (3) step();
    check("drain", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
